// File: rtl/regfile_wb.sv
// Integer register file at the MEM/WB writeback boundary: two bypassed read ports
// plus a per-register busy scoreboard that the ID-stage hazard logic consults.
module regfile_wb #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_write_i,
    input  logic [XLEN-1:0]   rd_data_i,
    input  logic              rs1_read_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic              rs1_busy_o,
    input  logic              rs2_read_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic              rs2_busy_o,
    input  logic              issue_set_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              flush_i,
    output logic [ADDR_W:0]   busy_cnt_o
);

    logic [XLEN-1:0]    regs [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;
    logic [ADDR_W:0]    busy_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
            end
        end else if (rd_write_i && rd_addr_i != '0) begin
            regs[rd_addr_i] <= rd_data_i;
        end
    end

    // Flush beats issue, issue beats writeback clear: the newest owner of rd wins.
    always_comb begin
        busy_next = busy;
        for (int r = 1; r < REG_NUM; r++) begin
            if (flush_i) begin
                busy_next[r] = 1'b0;
            end else if (issue_set_i && issue_addr_i == ADDR_W'(r)) begin
                busy_next[r] = 1'b1;
            end else if (rd_write_i && rd_addr_i == ADDR_W'(r)) begin
                busy_next[r] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_next = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            busy_cnt_next = busy_cnt_next + (ADDR_W + 1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_cnt_o <= '0;
        end else begin
            busy       <= busy_next;
            busy_cnt_o <= busy_cnt_next;
        end
    end

    always_comb begin
        rs1_data_o = '0;
        rs1_busy_o = 1'b0;
        if (!rst && rs1_read_i && rs1_addr_i != '0) begin
            if (rd_write_i && rd_addr_i == rs1_addr_i) begin
                rs1_data_o = rd_data_i;
            end else begin
                rs1_data_o = regs[rs1_addr_i];
                rs1_busy_o = busy[rs1_addr_i];
            end
        end
    end

    always_comb begin
        rs2_data_o = '0;
        rs2_busy_o = 1'b0;
        if (!rst && rs2_read_i && rs2_addr_i != '0) begin
            if (rd_write_i && rd_addr_i == rs2_addr_i) begin
                rs2_data_o = rd_data_i;
            end else begin
                rs2_data_o = regs[rs2_addr_i];
                rs2_busy_o = busy[rs2_addr_i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed-vector bench for regfile_wb: reset, writes, x0, bypass, scoreboard,
// flush and mid-operation reset, each against hand-computed expectations.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic        rd_write_i;
    logic [31:0] rd_data_i;
    logic        rs1_read_i;
    logic [4:0]  rs1_addr_i;
    logic [31:0] rs1_data_o;
    logic        rs1_busy_o;
    logic        rs2_read_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs2_data_o;
    logic        rs2_busy_o;
    logic        issue_set_i;
    logic [4:0]  issue_addr_i;
    logic        flush_i;
    logic [5:0]  busy_cnt_o;

    int testCount = 0;
    int failCount = 0;

    regfile_wb dut (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr_i), .rd_write_i(rd_write_i), .rd_data_i(rd_data_i),
        .rs1_read_i(rs1_read_i), .rs1_addr_i(rs1_addr_i),
        .rs1_data_o(rs1_data_o), .rs1_busy_o(rs1_busy_o),
        .rs2_read_i(rs2_read_i), .rs2_addr_i(rs2_addr_i),
        .rs2_data_o(rs2_data_o), .rs2_busy_o(rs2_busy_o),
        .issue_set_i(issue_set_i), .issue_addr_i(issue_addr_i),
        .flush_i(flush_i), .busy_cnt_o(busy_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic applyStimulus(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic iss, input logic [4:0] ia, input logic fl);
        rd_write_i   = wr;
        rd_addr_i    = wa;
        rd_data_i    = wd;
        issue_set_i  = iss;
        issue_addr_i = ia;
        flush_i      = fl;
    endtask

    task automatic setRead(input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
        rs1_read_i = r1;
        rs1_addr_i = a1;
        rs2_read_i = r2;
        rs2_addr_i = a2;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        setRead(1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        tick();
        rst = 1'b0;
        settle();

        checkOutput("reset_cnt", 32'(busy_cnt_o), 32'd0);
        for (int a = 1; a < 32; a++) begin
            setRead(1'b1, 5'(a), 1'b1, 5'(a));
            settle();
            checkOutput($sformatf("reset_rs1_x%0d", a), rs1_data_o, 32'h0);
            checkOutput($sformatf("reset_rs2_x%0d", a), rs2_data_o, 32'h0);
            checkOutput($sformatf("reset_busy_x%0d", a), 32'({rs1_busy_o, rs2_busy_o}), 32'd0);
        end

        // Plain write then read back
        tick();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        setRead(1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        setRead(1'b1, 5'd5, 1'b0, 5'd5);
        settle();
        checkOutput("write_x5", rs1_data_o, 32'hDEADBEEF);
        checkOutput("rs2_read_disabled", rs2_data_o, 32'h0);

        // x0 is hardwired, including the bypass path
        tick();
        applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b0);
        setRead(1'b1, 5'd0, 1'b0, 5'd0);
        settle();
        checkOutput("x0_bypass", rs1_data_o, 32'h0);
        tick();
        idle();
        settle();
        checkOutput("x0_after_write", rs1_data_o, 32'h0);

        // Bypass hides busy on a register being written this cycle
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        tick();
        idle();
        setRead(1'b0, 5'd0, 1'b1, 5'd7);
        settle();
        checkOutput("x7_busy", 32'(rs2_busy_o), 32'd1);
        checkOutput("x7_cnt", 32'(busy_cnt_o), 32'd1);
        tick();
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
        settle();
        checkOutput("bypass_data", rs2_data_o, 32'hA5A5A5A5);
        checkOutput("bypass_busy", 32'(rs2_busy_o), 32'd0);
        tick();
        idle();
        settle();
        checkOutput("x7_cleared_cnt", 32'(busy_cnt_o), 32'd0);
        checkOutput("x7_stored", rs2_data_o, 32'hA5A5A5A5);

        // Scoreboard set, clear, and simultaneous set+clear
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        setRead(1'b1, 5'd3, 1'b0, 5'd0);
        tick();
        idle();
        settle();
        checkOutput("x3_busy", 32'(rs1_busy_o), 32'd1);
        checkOutput("x3_cnt", 32'(busy_cnt_o), 32'd1);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0);
        tick();
        idle();
        settle();
        checkOutput("x3_clear_busy", 32'(rs1_busy_o), 32'd0);
        checkOutput("x3_clear_cnt", 32'(busy_cnt_o), 32'd0);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 1'b0);
        tick();
        idle();
        settle();
        checkOutput("x3_setwins_busy", 32'(rs1_busy_o), 32'd1);
        checkOutput("x3_setwins_cnt", 32'(busy_cnt_o), 32'd1);
        checkOutput("x3_setwins_data", rs1_data_o, 32'h44);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h45, 1'b0, 5'd0, 1'b0);
        tick();
        idle();
        settle();
        checkOutput("x3_drain_cnt", 32'(busy_cnt_o), 32'd0);

        // Issue to x0 is ignored
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        tick();
        idle();
        settle();
        checkOutput("x0_issue_cnt", 32'(busy_cnt_o), 32'd0);

        // Flush overrides a same-cycle issue; writeback data still lands
        for (int a = 1; a <= 3; a++) begin
            tick();
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b0);
        end
        tick();
        idle();
        settle();
        checkOutput("flush_pre_cnt", 32'(busy_cnt_o), 32'd3);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 1'b1);
        tick();
        idle();
        setRead(1'b1, 5'd4, 1'b1, 5'd1);
        settle();
        checkOutput("flush_cnt", 32'(busy_cnt_o), 32'd0);
        checkOutput("flush_x4_busy", 32'(rs1_busy_o), 32'd0);
        checkOutput("flush_x1_busy", 32'(rs2_busy_o), 32'd0);
        setRead(1'b1, 5'd2, 1'b0, 5'd0);
        settle();
        checkOutput("flush_x2_data", rs1_data_o, 32'h22);

        // Reset mid-operation drops the same-cycle writeback
        tick();
        applyStimulus(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 1'b0);
        setRead(1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        idle();
        settle();
        checkOutput("x9_data", rs1_data_o, 32'h55);
        checkOutput("x9_busy", 32'(rs1_busy_o), 32'd1);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 1'b0);
        settle();
        checkOutput("rst_rs1_data", rs1_data_o, 32'h0);
        checkOutput("rst_rs1_busy", 32'(rs1_busy_o), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        settle();
        checkOutput("rst_x9_data", rs1_data_o, 32'h0);
        checkOutput("rst_x9_busy", 32'(rs1_busy_o), 32'd0);
        checkOutput("rst_cnt", 32'(busy_cnt_o), 32'd0);
        setRead(1'b1, 5'd5, 1'b0, 5'd0);
        settle();
        checkOutput("rst_x5_data", rs1_data_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Integer register file, x0..x31. Receiving end of the MEM/WB writeback interface.
- Accepts writeback from the MEM/WB pipeline register and serves two combinational read ports to the ID stage, with same-cycle write bypass.
- Keeps a per-register busy scoreboard: ID marks a destination busy on issue, writeback clears it, and the hazard logic reads it.

Parameters:
- XLEN, 32, data width of each register.
- REG_NUM, 32, number of architectural registers.
- ADDR_W, 5, register address width (log2 REG_NUM).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- rd_addr_i  input  ADDR_W  writeback destination, from MEM/WB
- rd_write_i  input  1  writeback enable, from MEM/WB
- rd_data_i  input  XLEN  writeback data, from MEM/WB
- rs1_read_i  input  1  read-port-1 enable
- rs1_addr_i  input  ADDR_W  read-port-1 address
- rs1_data_o  output  XLEN  read-port-1 data (combinational)
- rs1_busy_o  output  1  rs1 has a pending write (combinational)
- rs2_read_i  input  1  read-port-2 enable
- rs2_addr_i  input  ADDR_W  read-port-2 address
- rs2_data_o  output  XLEN  read-port-2 data (combinational)
- rs2_busy_o  output  1  rs2 has a pending write (combinational)
- issue_set_i  input  1  ID issued an instruction that writes issue_addr_i
- issue_addr_i  input  ADDR_W  destination register of the issued instruction
- flush_i  input  1  pipeline flush (branch mispredict): clear all busy bits
- busy_cnt_o  output  ADDR_W+1  number of busy registers (registered)

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - All registers become 0 and all busy bits become 0.
  - busy_cnt_o = 0.
  - rsN_data_o and rsN_busy_o are 0 while rst is high.
- Write:
  - On a rising edge with rd_write_i=1 and rd_addr_i!=0, regs[rd_addr_i] <= rd_data_i.
  - Writes to x0 are ignored; x0 always reads 0.
- Read (combinational):
  - rsN_read_i=0 gives 0.
  - rsN_addr_i=0 gives 0.
  - Otherwise, if rd_write_i=1 and rd_addr_i==rsN_addr_i, output rd_data_i (bypass, zero-latency forwarding from WB).
  - Otherwise output regs[rsN_addr_i].
- Busy scoreboard (clocked):
  - Per register r!=0, with rr = rd_write_i && rd_addr_i==r and ss = issue_set_i && issue_addr_i==r:
    - flush_i=1: busy <= 0 for all r. This overrides issue_set_i in the same cycle, and the writeback still updates data.
    - ss: busy <= 1. Set wins over a simultaneous clear, because the newer instruction owns rd.
    - rr && !ss: busy <= 0.
    - Else hold.
  - busy[0] is constantly 0; issue to x0 is ignored.
- busy_cnt_o: registered popcount of the next busy vector, so it equals the popcount of busy after each edge.
- Busy read (combinational):
  - rsN_busy_o = rsN_read_i && rsN_addr_i!=0 && busy[rsN_addr_i] && !(rd_write_i && rd_addr_i==rsN_addr_i).
  - A register being written back this cycle reads not-busy, since the bypass supplies its data.
- Redundant writeback (rd_write_i to a non-busy register): data is written and busy stays 0; this is not an error.
- Reset mid-operation: all state clears on that edge; pending writebacks and issues in the same cycle are dropped.
- No internal stall input. The writeback source delivers a bubble (rd_write_i=0) when stalled.

Test Plan:
- Reset, then read x1..x31 on both ports -> all 0; busy_cnt_o=0.
- Write x5=0xDEADBEEF, next cycle read rs1=x5 -> 0xDEADBEEF. Write x0=0x1234, then read x0 -> 0.
- Same-cycle bypass: rd_write_i=1, rd_addr_i=7, rd_data_i=0xA5A5A5A5, rs2_addr_i=7 -> rs2_data_o=0xA5A5A5A5 in that cycle, with rs2_busy_o=0 even if busy[7]=1.
- Scoreboard set/clear:
  - issue x3 -> next cycle rs1_busy_o=1, busy_cnt_o=1.
  - Writeback x3 -> the following cycle busy=0, busy_cnt_o=0.
  - Simultaneous issue x3 and writeback x3 -> busy[3]=1 afterwards, data updated.
- Flush: issue x1, x2, x3 over three cycles (busy_cnt_o=3), then flush_i=1 together with issue x4 -> all busy 0, busy_cnt_o=0.
- Reset mid-operation: x9=0x55 and busy[9]=1, assert rst one cycle together with rd_write_i to x9 -> x9 reads 0, busy 0, busy_cnt_o=0.
